// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned NxN shift-add multiplier: one add/shift step per clock,
// registered 2N-bit product with a one-cycle done pulse (start/done handshake).
module seq_shift_add_multiplier #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   multiplicand,
   input  logic [N-1:0]   multiplier,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_nxt_s;
   logic [N-1:0]  a_r;
   logic [N-1:0]  q_r;
   logic [N:0]    acc_r;
   logic [CW-1:0] cnt_r;
   logic [N:0]    sum_s;
   logic [N-1:0]  q_nxt_s;
   logic          load_s;
   logic          step_s;
   logic          finish_s;

   // One add/shift step; acc_r[N] is always zero on entry, so the carry lands in sum_s[N].
   always_comb begin
      sum_s   = acc_r;
      q_nxt_s = q_r;
      if (q_r[0] == 1'b1) begin
         sum_s = acc_r + {1'b0, a_r};
      end else begin
         sum_s = acc_r;
      end
      q_nxt_s = {sum_s[0], q_r[N-1:1]};
   end

   // Next-state and datapath control decode.
   always_comb begin
      state_nxt_s = state_r;
      load_s      = 1'b0;
      step_s      = 1'b0;
      finish_s    = 1'b0;
      case (state_r)
         S_IDLE, S_DONE: begin
            if (start == 1'b1) begin
               load_s      = 1'b1;
               state_nxt_s = S_BUSY;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_BUSY: begin
            step_s = 1'b1;
            if (cnt_r == CW'(1)) begin
               finish_s    = 1'b1;
               state_nxt_s = S_DONE;
            end else begin
               state_nxt_s = S_BUSY;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // State register with registered Moore status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy    <= (state_nxt_s == S_BUSY);
         done    <= (state_nxt_s == S_DONE);
      end
   end

   // Operand capture and shift-add datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= {N{1'b0}};
         q_r   <= {N{1'b0}};
         acc_r <= {(N+1){1'b0}};
         cnt_r <= {CW{1'b0}};
      end else if (load_s) begin
         a_r   <= multiplicand;
         q_r   <= multiplier;
         acc_r <= {(N+1){1'b0}};
         cnt_r <= CW'(N);
      end else if (step_s) begin
         acc_r <= {1'b0, sum_s[N:1]};
         q_r   <= q_nxt_s;
         cnt_r <= cnt_r - CW'(1);
      end else begin
         a_r   <= a_r;
         q_r   <= q_r;
         acc_r <= acc_r;
         cnt_r <= cnt_r;
      end
   end

   // Product is written only on the final step and held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         product <= {(2*N){1'b0}};
      end else if (finish_s) begin
         product <= {sum_s[N:1], q_nxt_s};
      end else begin
         product <= product;
      end
   end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier (N=4) against plain A*B arithmetic.
module tb_seq_shift_add_multiplier;

   localparam int N = 4;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [N-1:0]   multiplicand;
   logic [N-1:0]   multiplier;
   logic           busy;
   logic           done;
   logic [2*N-1:0] product;

   int             errors;
   int             checks;
   int             done_seen;
   logic [2*N-1:0] last_prod;

   seq_shift_add_multiplier #(.N(N)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done === 1'b1) done_seen <= done_seen + 1;
   end

   function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
      return (2*N)'(a) * (2*N)'(b);
   endfunction

   // Present operands with start for one edge; afterwards scramble operands.
   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
      start = 1'b1;
      multiplicand = a;
      multiplier = b;
      @(posedge clk); #1;
      start = 1'b0;
      multiplicand = N'($urandom);
      multiplier = N'($urandom);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0)
         begin errors++; $display("FAIL accept: busy=%b done=%b required busy=1 done=0", busy, done); end
   endtask

   // Wait for done (bounded); check busy, held product, latency and result.
   task automatic wait_done(input int lat0, input logic [2*N-1:0] exp);
      int lat;
      lat = lat0;
      while (done !== 1'b1 && lat < N + 4) begin
         checks++;
         if (busy !== 1'b1 || product !== last_prod) begin
            errors++;
            $display("FAIL busy_hold: lat=%0d busy=%b product=%h required busy=1 product=%h", lat, busy, product, last_prod);
         end
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat != N)
         begin errors++; $display("FAIL latency: got %0d required %0d", lat, N); end
      checks++;
      if (product !== exp || busy !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL product: got %h busy=%b done=%b required %h busy=0 done=1", product, busy, done, exp);
      end
      last_prod = exp;
   endtask

   task automatic check_idle(input string name);
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || product !== last_prod)
         begin errors++; $display("FAIL %s: busy=%b done=%b product=%h required 0 0 %h", name, busy, done, product, last_prod); end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b0;
      multiplicand = '0;
      multiplier = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      last_prod = '0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00)
         begin errors++; $display("FAIL reset: busy=%b done=%b product=%h required 0 0 00", busy, done, product); end
   endtask

   task automatic test_directed;
      issue(4'd0, 4'd13);   wait_done(0, ref_mul(4'd0, 4'd13));  check_idle("idle_0x13");
      issue(4'd15, 4'd15);  wait_done(0, 8'hE1);                 check_idle("idle_15x15");
      checks++;
      if (last_prod !== 8'hE1) begin errors++; $display("FAIL ref_225: got %h required e1", last_prod); end
   endtask

   task automatic test_back_to_back;
      issue(4'd9, 4'd6);
      wait_done(0, 8'h36);
      issue(4'd3, 4'd5);    // accepted during the done cycle
      wait_done(0, 8'h0F);
      check_idle("idle_b2b");
   endtask

   task automatic test_start_ignored;
      int d0;
      d0 = done_seen;
      issue(4'd7, 4'd7);
      start = 1'b1; multiplicand = 4'd1; multiplier = 4'd1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(1, 8'h31);
      check_idle("idle_ignored");
      repeat (N) check_idle("hold_ignored");
      checks++;
      if (done_seen - d0 != 1)
         begin errors++; $display("FAIL single_done: got %0d pulses required 1", done_seen - d0); end
   endtask

   task automatic test_reset_abort;
      int d0;
      issue(4'd12, 4'd10);
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1;
      last_prod = '0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00)
         begin errors++; $display("FAIL async_reset: busy=%b done=%b product=%h required 0 0 00", busy, done, product); end
      @(negedge clk);
      rst_n = 1'b1;
      d0 = done_seen;
      repeat (N + 2) check_idle("post_reset");
      checks++;
      if (done_seen != d0)
         begin errors++; $display("FAIL abort_no_done: got %0d pulses required 0", done_seen - d0); end
      issue(4'd12, 4'd10);
      wait_done(0, 8'h78);
      check_idle("idle_12x10");
   endtask

   task automatic test_random;
      logic [N-1:0] a, b;
      for (int i = 0; i < 20; i++) begin
         a = N'($urandom);
         b = N'($urandom);
         issue(a, b);
         wait_done(0, ref_mul(a, b));
         repeat ($urandom_range(0, 2)) check_idle("idle_rand");
         @(posedge clk); #1;
      end
   endtask

   task automatic test_exhaustive;
      int d0;
      logic [N-1:0] a, b;
      d0 = done_seen;
      for (int i = 0; i < 256; i++) begin
         a = N'(i >> 4);
         b = N'(i);
         issue(a, b);
         wait_done(0, ref_mul(a, b));
      end
      check_idle("idle_exh");
      checks++;
      if (done_seen - d0 != 256)
         begin errors++; $display("FAIL done_count: got %0d required 256", done_seen - d0); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      done_seen = 0;
      last_prod = '0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_start_ignored();
      test_reset_abort();
      test_random();
      test_exhaustive();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
